// File: rtl/alu_arbiter.sv
// Two-requester front end sharing one ALU: grant, sequence EXEC latency, hold response.
// Define ALU_ARB_FIXED_PRIO_EN to make requester 0 win every tie (round-robin otherwise).
module alu_arbiter #(
    parameter int n          = 32,
    parameter int MULDIV_LAT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [n-1:0] req0_a,
    input  logic [n-1:0] req0_b,
    input  logic [5:0]   req0_op,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [n-1:0] req1_a,
    input  logic [n-1:0] req1_b,
    input  logic [5:0]   req1_op,
    output logic [n-1:0] alu_a,
    output logic [n-1:0] alu_b,
    output logic [5:0]   alu_op,
    input  logic [n-1:0] alu_result,
    input  logic [12:0]  alu_flags,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [n-1:0] rsp_result,
    output logic [12:0]  rsp_flags,
    output logic         busy
);

    localparam logic [3:0] LAT_M1 = 4'(MULDIV_LAT - 1);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t       r_state;
    logic [3:0]   r_cnt;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic         r_last;
`endif

    logic         w_any;
    logic         w_gid;
    logic [n-1:0] w_a;
    logic [n-1:0] w_b;
    logic [5:0]   w_op;
    logic         w_muldiv;

    // Ready is combinational so the grant and the operand latch share one cycle.
    always_comb begin
        w_any = (r_state == IDLE) && !rst && (req0_valid || req1_valid);
`ifdef ALU_ARB_FIXED_PRIO_EN
        w_gid = !req0_valid;
`else
        w_gid = (req0_valid && req1_valid) ? !r_last : !req0_valid;
`endif
        w_a      = w_gid ? req1_a  : req0_a;
        w_b      = w_gid ? req1_b  : req0_b;
        w_op     = w_gid ? req1_op : req0_op;
        w_muldiv = (w_op == 6'b000100) || (w_op == 6'b000101);
    end

    assign req0_ready = w_any && !w_gid;
    assign req1_ready = w_any &&  w_gid;

    // alu_a/b/op double as the operand latch; they are zeroed on leaving EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            r_last     <= 1'b1;
`endif
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            busy       <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        alu_a   <= w_a;
                        alu_b   <= w_b;
                        alu_op  <= w_op;
                        rsp_id  <= w_gid;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        r_last  <= w_gid;
`endif
                        r_cnt   <= w_muldiv ? LAT_M1 : 4'd0;
                        busy    <= 1'b1;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    if (r_cnt == 4'd0) begin
                        rsp_result <= alu_result;
                        rsp_flags  <= alu_flags;
                        rsp_valid  <= 1'b1;
                        alu_a      <= '0;
                        alu_b      <= '0;
                        alu_op     <= '0;
                        r_state    <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: n, default 32, operand/result width; SHALL match the shared alu instance.
REQ-002 Parameter: MULDIV_LAT, default 4, EXEC cycles for opcodes 6'b000100 (div) and 6'b000101 (mult); legal range 1..15.
REQ-003 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Ports: req0_valid / req1_valid  input  1  requester has an operation pending.
REQ-006 Ports: req0_ready / req1_ready  output  1  request accepted this cycle.
REQ-007 Ports: req0_a, req0_b, req1_a, req1_b  input  n  operands.
REQ-008 Ports: req0_op, req1_op  input  6  alu control code.
REQ-009 Ports: alu_a, alu_b  output  n; alu_op  output  6; all three drive the alu inputs.
REQ-010 Port: alu_result  input  n  alu salida.
REQ-011 Port: alu_flags  input  13  {se,seqe,slte,slee,sgte,sgee,sle2..sle8}, se at MSB.
REQ-012 Ports: rsp_valid  output  1; rsp_ready  input  1; rsp_id  output  1 (originating requester); rsp_result  output  n; rsp_flags  output  13.
REQ-013 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-014 FSM states SHALL be IDLE, EXEC, RESP; exactly one operation is in flight at a time.
REQ-015 IDLE: if any reqX_valid, the block SHALL grant one requester, assert only its reqX_ready for that single cycle, latch its a/b/op and id, and go to EXEC.
REQ-016 reqX_ready SHALL be 0 in EXEC and RESP, and 0 in IDLE for a non-granted requester.
REQ-017 Grant, one requester valid: that requester. Both valid: the requester not granted most recently (round-robin pointer updated on every grant).
REQ-018 On accept, the cycle counter SHALL load MULDIV_LAT-1 for op 6'b000100/6'b000101, else 0.
REQ-019 EXEC: alu_a/alu_b/alu_op SHALL drive the latched values; if counter==0, capture alu_result into rsp_result, alu_flags into rsp_flags, and go to RESP; otherwise decrement.
REQ-020 Outside EXEC, alu_op SHALL be 6'b000000 and alu_a/alu_b SHALL be 0.
REQ-021 Latency: with accept at cycle T, rsp_valid SHALL rise at T+2 for single-cycle ops and at T+1+MULDIV_LAT for div/mult.
REQ-022 RESP: rsp_valid=1; rsp_id/rsp_result/rsp_flags SHALL stay stable until rsp_valid&rsp_ready, then the FSM goes to IDLE.
REQ-023 A new request SHALL NOT be accepted in the cycle the response handshake completes; the earliest accept is the following cycle.
REQ-024 Undefined op codes SHALL be sequenced as single-cycle ops; the result is whatever alu returns.
REQ-025 Requester signals SHALL be ignored while not ready; changes after accept SHALL NOT affect the in-flight operation.

Reset
REQ-026 On rst: state=IDLE, counter=0, round-robin pointer = requester 1 (so requester 0 wins the first tie), rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, req0_ready=req1_ready=0, busy=0, alu_op=0.
REQ-027 rst asserted mid-EXEC or mid-RESP SHALL abort the operation with no response issued.

Configuration
REQ-028 Macro ALU_ARB_FIXED_PRIO_EN defined: when both requesters are valid, requester 0 SHALL always be granted, and the round-robin pointer is unused.
REQ-029 Macro ALU_ARB_FIXED_PRIO_EN undefined: the round-robin grant of REQ-017 applies.

Verification
REQ-030 After reset, req0 only, op=6'b000001, a=5, b=7 -> req0_ready one cycle at T; rsp_valid at T+2; rsp_result=12; rsp_id=0.
REQ-031 Both valid from reset, req0 op=000010 a=9 b=4, req1 op=000111 a=8'h0F b=8'hF0 -> req0 served first (result 5), then req1 (result 8'hFF), rsp_ready held 1. With ALU_ARB_FIXED_PRIO_EN and req0 held valid, req1 is never granted.
REQ-032 req1 op=000101, a=6, b=7, MULDIV_LAT=4 -> rsp_valid at T+5, result 42; busy=1 from T+1 through the handshake cycle.
REQ-033 Op 6'b001101, a=b=3 -> rsp_flags=13'b0_1000_0000_0000 (seqe bit set).
REQ-034 Hold rsp_ready=0 for 5 cycles in RESP -> rsp fields constant, both readys 0; release -> handshake, then IDLE.
REQ-035 Assert rst for one cycle during a div EXEC -> no rsp_valid; next request served normally, with req0 winning the next tie.
